count_monitor: RTL and testbench
================================

# count_monitor

Downstream observer for the 4-bit up/down counter. Samples the counter value `q` and its `mode` every cycle, then:
- flags wrap-around in either direction;
- keeps a saturating wrap tally;
- detects a programmable match value;
- detects illegal steps and stalls;
- raises a sticky interrupt for the control logic.

It is purely an observer: it never drives the counter.

## Interface
- `WRAP_W`, 8: width of the saturating wrap counter.
- `STALL_LIM`, 4: consecutive unchanged samples that declare a stall (range 2..15).

- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `q` input 4: counter value.
- `mode` input 1: counter direction, 1 up, 0 down.
- `match_val` input 4: value to detect.
- `match_en` input 1: enables match detection.
- `irq_clr` input 1: one-cycle pulse that clears the sticky flags.
- `wrap_up` output 1: one-cycle pulse on a 15→0 step in up mode.
- `wrap_dn` output 1: one-cycle pulse on a 0→15 step in down mode.
- `wrap_cnt` output WRAP_W: saturating count of all wraps.
- `match_hit` output 1: sticky; q equalled match_val while match_en was high.
- `seq_err` output 1: sticky; illegal step observed.
- `stalled` output 1: level; high while in S_STALL.
- `irq` output 1: `match_hit | seq_err`.

## Operation
- Internal registers:
  - `prev_q`, `prev_mode`: last sample.
  - `same_cnt`, 4 bits: run length of unchanged samples.
  - state.
- States: S_INIT, S_RUN, S_STALL.
- S_INIT:
  - Entered on reset.
  - Captures `prev_q`/`prev_mode`.
  - No step checks, but match detection is active.
  - Goes to S_RUN next cycle.
- Step classification in S_RUN and S_STALL, comparing `q` against `prev_q`/`prev_mode`:
  - Legal up step: `q == prev_q + 1` (mod 16). Wrap-up if `prev_q == 4'hF`.
  - Legal down step: `q == prev_q - 1` (mod 16). Wrap-down if `prev_q == 4'h0`.
  - Hold: `q == prev_q`. Increment `same_cnt`, saturating at 15. Any change resets `same_cnt` to 0.
  - Any other value is illegal and sets `seq_err`. This includes a step opposite to `prev_mode`, other than via hold.
- The step direction is judged by `prev_mode`, not the current `mode`. A `mode` change alone is never an error.
- `wrap_cnt` increments on each wrap pulse and saturates at all-ones. It is cleared only by reset.
- `match_hit` sets when `match_en && q == match_val`. Checked in every state, including S_INIT.
- Transitions:
  - S_RUN → S_STALL when `same_cnt` reaches `STALL_LIM - 1` while a further hold is observed, i.e. after STALL_LIM equal samples.
  - S_STALL → S_RUN on the first changed sample. That sample is still classified normally.
- Sticky clear: `irq_clr` clears `match_hit` and `seq_err`. If a set condition occurs in the same cycle, the set wins and the flag stays 1.

## Timing
- All outputs are registered. A condition present on `q` in cycle t is visible on the outputs in cycle t+1.
- `wrap_up`/`wrap_dn` are exactly one cycle wide. Back-to-back wraps are impossible with a legal counter.
- `irq` is registered alongside the flags, with no extra cycle.
- `stalled` rises on the cycle after the STALL_LIM-th equal sample and falls the cycle after the first change.
- Reset (`reset_n` low at a rising edge) forces:
  - state to S_INIT;
  - `prev_q`, `prev_mode`, `same_cnt` to 0;
  - `wrap_up`, `wrap_dn`, `match_hit`, `seq_err`, `stalled`, `irq` to 0;
  - `wrap_cnt` to 0.
- Reset mid-operation discards any pending event. The first cycle after reset is S_INIT, so a jump on `q` caused by the counter's own reset is not flagged.
- `irq_clr` takes effect at the next edge: the flag reads 0 in cycle t+1 unless re-set.

## Structure
- Package `count_monitor_pkg`:
  - state enum (S_INIT, S_RUN, S_STALL);
  - `Q_W = 4`, `Q_MAX = 4'hF`, `Q_MIN = 4'h0`;
  - step-class enum (STEP_UP, STEP_DN, STEP_HOLD, STEP_ILLEGAL).
- One sub-module, `count_step_classifier`: combinational. Inputs `q`, `prev_q`, `prev_mode`. Outputs the step class and a wrap flag. It is reused by the bench as a reference model.
- The top holds the FSM, history registers, `same_cnt`, sticky flags and `wrap_cnt`.

## Test plan
- Up-count wrap: release reset, mode=1, drive q 0..15,0 → `wrap_up` is a single pulse the cycle after q=0; `wrap_cnt`=1; no `seq_err`.
- Down-count wrap: mode=0, drive q 2,1,0,15,14 → `wrap_dn` pulse after 15; `wrap_cnt` increments by 1; `wrap_up` stays 0.
- Match and clear: `match_en`=1, `match_val`=9, counting up → `match_hit`/`irq` rise the cycle after q=9. Pulse `irq_clr` on a cycle where q≠9 → both go to 0. Pulse `irq_clr` exactly when q=9 → `match_hit` stays 1.
- Illegal step: mode=1, drive q 3,4,7 → `seq_err`=1 and `irq`=1 the cycle after 7. Mode flip with a legal down step (5,4 after mode→0) → no error.
- Stall: STALL_LIM=4, hold q=6 for 5 cycles → `stalled` high after the 4th equal sample. q=7 → `stalled` low the next cycle, no error.
- Saturation and reset: force 300 wraps with WRAP_W=8 → `wrap_cnt`=255. Assert `reset_n` low mid-count → all outputs 0. The q jump to 0 after reset is not flagged.

Source files
------------

// File: rtl/count_monitor_pkg.sv
// Shared types and constants for the 4-bit counter observer.
package count_monitor_pkg;

  localparam int unsigned Q_W = 4;
  localparam logic [Q_W-1:0] Q_MAX = 4'hF;
  localparam logic [Q_W-1:0] Q_MIN = 4'h0;

  // Monitor FSM states.
  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_STALL
  } state_e;

  // Classification of one counter sample against the previous one.
  typedef enum logic [1:0] {
    STEP_UP,
    STEP_DN,
    STEP_HOLD,
    STEP_ILLEGAL
  } step_e;

  // Modulo-16 neighbours of a counter value.
  function automatic logic [Q_W-1:0] q_inc(input logic [Q_W-1:0] v);
    return v + 4'd1;
  endfunction

  function automatic logic [Q_W-1:0] q_dec(input logic [Q_W-1:0] v);
    return v - 4'd1;
  endfunction

endpackage

// File: rtl/count_step_classifier.sv
// Combinational step classifier: compares a new counter sample with the
// previous sample and the direction the counter was in at that time.
module count_step_classifier
  import count_monitor_pkg::*;
(
  input  logic [Q_W-1:0] q,
  input  logic [Q_W-1:0] prev_q,
  input  logic           prev_mode,
  output step_e          step,
  output logic           wrap
);

  // Direction is judged by the mode that produced prev_q; a step against it is illegal.
  always_comb begin
    step = STEP_ILLEGAL;
    wrap = 1'b0;
    if (q == prev_q) begin
      step = STEP_HOLD;
    end else if (prev_mode && (q == q_inc(prev_q))) begin
      step = STEP_UP;
      wrap = (prev_q == Q_MAX);
    end else if (!prev_mode && (q == q_dec(prev_q))) begin
      step = STEP_DN;
      wrap = (prev_q == Q_MIN);
    end
  end

endmodule

// File: rtl/count_monitor.sv
// Passive observer for the 4-bit up/down counter: wrap pulses, saturating
// wrap tally, match detection, illegal-step and stall detection, sticky irq.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int unsigned WRAP_W    = 8,
  parameter int unsigned STALL_LIM = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [Q_W-1:0]    q,
  input  logic              mode,
  input  logic [Q_W-1:0]    match_val,
  input  logic              match_en,
  input  logic              irq_clr,
  output logic              wrap_up,
  output logic              wrap_dn,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              match_hit,
  output logic              seq_err,
  output logic              stalled,
  output logic              irq
);

  // Hold count at which a further hold declares a stall.
  localparam logic [3:0] HoldLim = 4'(STALL_LIM - 1);
  localparam logic [3:0] SameMax = 4'hF;

  state_e              state_q, state_d;
  logic [Q_W-1:0]      prev_q_q, prev_q_d;
  logic                prev_mode_q, prev_mode_d;
  logic [3:0]          same_cnt_q, same_cnt_d;
  logic                wrap_up_q, wrap_up_d;
  logic                wrap_dn_q, wrap_dn_d;
  logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic                match_hit_q, match_hit_d;
  logic                seq_err_q, seq_err_d;
  logic                stalled_q, stalled_d;
  logic                irq_q, irq_d;

  step_e               step;
  logic                step_wrap;
  logic                illegal;
  logic                match_now;

  count_step_classifier u_classifier (
    .q         (q),
    .prev_q    (prev_q_q),
    .prev_mode (prev_mode_q),
    .step      (step),
    .wrap      (step_wrap)
  );

  // FSM next state, history capture, hold run length and wrap pulses.
  always_comb begin
    state_d     = state_q;
    prev_q_d    = q;
    prev_mode_d = mode;
    same_cnt_d  = same_cnt_q;
    wrap_up_d   = 1'b0;
    wrap_dn_d   = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_INIT: begin
        // Only captures history; a reset-induced jump on q is never judged.
        state_d    = S_RUN;
        same_cnt_d = '0;
      end
      S_RUN, S_STALL: begin
        if (step == STEP_HOLD) begin
          if (same_cnt_q != SameMax) begin
            same_cnt_d = same_cnt_q + 4'd1;
          end
          if ((state_q == S_RUN) && (same_cnt_q >= HoldLim)) begin
            state_d = S_STALL;
          end
        end else begin
          same_cnt_d = '0;
          state_d    = S_RUN;
          wrap_up_d  = (step == STEP_UP) && step_wrap;
          wrap_dn_d  = (step == STEP_DN) && step_wrap;
          illegal    = (step == STEP_ILLEGAL);
        end
      end
      default: begin
        state_d    = S_INIT;
        same_cnt_d = '0;
      end
    endcase
  end

  // Saturating wrap tally, sticky flags (set beats clear) and registered irq.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if ((wrap_up_d || wrap_dn_d) && (wrap_cnt_q != {WRAP_W{1'b1}})) begin
      wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
    end
    match_now   = match_en && (q == match_val);
    match_hit_d = match_now || (match_hit_q && !irq_clr);
    seq_err_d   = illegal || (seq_err_q && !irq_clr);
    irq_d       = match_hit_d || seq_err_d;
    stalled_d   = (state_d == S_STALL);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_INIT;
      prev_q_q    <= '0;
      prev_mode_q <= 1'b0;
      same_cnt_q  <= '0;
      wrap_up_q   <= 1'b0;
      wrap_dn_q   <= 1'b0;
      wrap_cnt_q  <= '0;
      match_hit_q <= 1'b0;
      seq_err_q   <= 1'b0;
      stalled_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q_q    <= prev_q_d;
      prev_mode_q <= prev_mode_d;
      same_cnt_q  <= same_cnt_d;
      wrap_up_q   <= wrap_up_d;
      wrap_dn_q   <= wrap_dn_d;
      wrap_cnt_q  <= wrap_cnt_d;
      match_hit_q <= match_hit_d;
      seq_err_q   <= seq_err_d;
      stalled_q   <= stalled_d;
      irq_q       <= irq_d;
    end
  end

  assign wrap_up   = wrap_up_q;
  assign wrap_dn   = wrap_dn_q;
  assign wrap_cnt  = wrap_cnt_q;
  assign match_hit = match_hit_q;
  assign seq_err   = seq_err_q;
  assign stalled   = stalled_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: directed vector table, hand sequences for
// saturation/reset, then random stimulus against a behavioural model.
module tb_count_monitor;

  localparam int unsigned WRAP_W    = 8;
  localparam int unsigned STALL_LIM = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [3:0]        q;
  logic              mode;
  logic [3:0]        match_val;
  logic              match_en;
  logic              irq_clr;
  logic              wrap_up;
  logic              wrap_dn;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              match_hit;
  logic              seq_err;
  logic              stalled;
  logic              irq;

  int tests = 0;
  int failed = 0;

  count_monitor #(
    .WRAP_W    (WRAP_W),
    .STALL_LIM (STALL_LIM)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .q         (q),
    .mode      (mode),
    .match_val (match_val),
    .match_en  (match_en),
    .irq_clr   (irq_clr),
    .wrap_up   (wrap_up),
    .wrap_dn   (wrap_dn),
    .wrap_cnt  (wrap_cnt),
    .match_hit (match_hit),
    .seq_err   (seq_err),
    .stalled   (stalled),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Flags packed as {wrap_up, wrap_dn, match_hit, seq_err, stalled, irq}.
  typedef struct {
    logic       rn;
    logic [3:0] q;
    logic       m;
    logic       men;
    logic [3:0] mv;
    logic       clr;
    logic [7:0] wc;
    logic [5:0] flags;
  } vec_t;

  function automatic vec_t mk(logic rn, int qv, logic m, logic men, int mv, logic clr,
                              int wc, logic [5:0] flags);
    vec_t v;
    v.rn = rn; v.q = 4'(qv); v.m = m; v.men = men; v.mv = 4'(mv); v.clr = clr;
    v.wc = 8'(wc); v.flags = flags;
    return v;
  endfunction

  // Behavioural model: what the observer must report, derived from the rules.
  bit first_m;
  int prev_qm;
  bit prev_mm;
  int holds_m;
  int wc_m;
  bit mh_m, se_m;
  logic [5:0] exp_flags;
  int exp_wc;

  task automatic model_step(input logic rn, input int qv, input logic m, input logic men,
                            input int mv, input logic clr);
    bit wu, wd, err, hit;
    wu = 0; wd = 0; err = 0;
    if (!rn) begin
      first_m = 1; prev_qm = 0; prev_mm = 0; holds_m = 0; wc_m = 0; mh_m = 0; se_m = 0;
      exp_flags = '0;
      exp_wc = 0;
      return;
    end
    hit = men && (qv == mv);
    if (first_m) begin
      first_m = 0;
      holds_m = 0;
    end else if (qv == prev_qm) begin
      if (holds_m < 15) holds_m++;
    end else begin
      holds_m = 0;
      if (prev_mm && qv == (prev_qm + 1) % 16) wu = (prev_qm == 15);
      else if (!prev_mm && qv == (prev_qm + 15) % 16) wd = (prev_qm == 0);
      else err = 1;
    end
    if ((wu || wd) && wc_m < 255) wc_m++;
    mh_m = hit || (mh_m && !clr);
    se_m = err || (se_m && !clr);
    prev_qm = qv;
    prev_mm = m;
    exp_flags = {wu, wd, mh_m, se_m, (holds_m >= STALL_LIM), mh_m || se_m};
    exp_wc = wc_m;
  endtask

  // Drive one sample, keep the model in step, and sample outputs just after the edge.
  task automatic apply(input logic rn, input int qv, input logic m, input logic men,
                       input int mv, input logic clr);
    reset_n = rn; q = 4'(qv); mode = m; match_en = men; match_val = 4'(mv); irq_clr = clr;
    model_step(rn, qv, m, men, mv, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input int ewc,
                       input logic [5:0] eflags);
    logic [5:0] got;
    got = {wrap_up, wrap_dn, match_hit, seq_err, stalled, irq};
    tests++;
    if (got !== eflags || wrap_cnt !== WRAP_W'(ewc)) begin
      failed++;
      $display("FAIL %s[%0d]: got flags(wu,wd,mh,se,st,irq)=%b wrap_cnt=%0d, expected %b %0d",
               name, idx, got, wrap_cnt, eflags, ewc);
    end
  endtask

  vec_t tbl[$];

  initial begin
    reset_n = 0; q = 0; mode = 0; match_val = 0; match_en = 0; irq_clr = 0;

    // rn, q, mode, men, mval, clr, expected wrap_cnt, expected {wu,wd,mh,se,st,irq}
    tbl.push_back(mk(0,  0, 1, 0,  0, 0, 0, 6'b000000)); // reset
    tbl.push_back(mk(1,  5, 1, 0,  0, 0, 0, 6'b000000)); // init capture, jump ignored
    tbl.push_back(mk(1,  6, 1, 0,  0, 0, 0, 6'b000000));
    tbl.push_back(mk(1,  7, 1, 0,  0, 0, 0, 6'b000000));
    tbl.push_back(mk(1, 10, 1, 0,  0, 0, 0, 6'b000101)); // illegal jump
    tbl.push_back(mk(1, 11, 1, 0,  0, 1, 0, 6'b000000)); // clear
    tbl.push_back(mk(1, 11, 0, 0,  0, 0, 0, 6'b000000)); // mode flip on hold
    tbl.push_back(mk(1, 10, 0, 0,  0, 0, 0, 6'b000000)); // legal down
    tbl.push_back(mk(1, 15, 1, 0,  0, 0, 0, 6'b000101)); // illegal vs prev_mode
    tbl.push_back(mk(1,  0, 1, 0,  0, 1, 1, 6'b100000)); // wrap up, clear
    tbl.push_back(mk(1,  1, 1, 0,  0, 0, 1, 6'b000000));
    tbl.push_back(mk(1,  1, 0, 1,  1, 0, 1, 6'b001001)); // match
    tbl.push_back(mk(1,  0, 0, 1,  1, 1, 1, 6'b000000)); // clear, no re-hit
    tbl.push_back(mk(1, 15, 0, 0,  0, 0, 2, 6'b010000)); // wrap down
    tbl.push_back(mk(1, 15, 0, 1, 15, 1, 2, 6'b001001)); // set beats clear
    tbl.push_back(mk(1, 15, 0, 0,  0, 0, 2, 6'b001001));
    tbl.push_back(mk(1, 15, 0, 0,  0, 0, 2, 6'b001001)); // 3rd hold
    tbl.push_back(mk(1, 15, 0, 0,  0, 0, 2, 6'b001011)); // 4th hold: stalled
    tbl.push_back(mk(1, 15, 0, 0,  0, 0, 2, 6'b001011));
    tbl.push_back(mk(1, 14, 0, 0,  0, 0, 2, 6'b001001)); // leave stall, legal
    tbl.push_back(mk(0, 14, 0, 0,  0, 0, 0, 6'b000000)); // reset clears all
    tbl.push_back(mk(1,  9, 1, 0,  0, 0, 0, 6'b000000)); // init
    tbl.push_back(mk(1,  3, 1, 0,  0, 0, 0, 6'b000101)); // illegal in run

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      apply(tbl[i].rn, int'(tbl[i].q), tbl[i].m, tbl[i].men, int'(tbl[i].mv), tbl[i].clr);
      check("table", i, int'(tbl[i].wc), tbl[i].flags);
    end

    // Saturation: 300 up-wraps, ending away from a wrap.
    begin
      int qv;
      apply(0, 0, 1, 0, 0, 0);
      apply(1, 0, 1, 0, 0, 0);
      qv = 0;
      for (int n = 0; n < 300 * 16 + 3; n++) begin
        qv = (qv + 1) % 16;
        apply(1, qv, 1, 0, 0, 0);
      end
      check("saturate", qv, 255, 6'b000000);
      // Mid-count reset, then an arbitrary first sample must not be flagged.
      apply(0, 12, 1, 0, 0, 0);
      check("mid_reset", 0, 0, 6'b000000);
      apply(1, 7, 1, 0, 0, 0);
      check("post_reset_jump", 0, 0, 6'b000000);
      apply(1, 8, 1, 0, 0, 0);
      check("post_reset_step", 0, 0, 6'b000000);
    end

    // Stall entry and exit on a hand sequence.
    begin
      apply(1, 9, 1, 0, 0, 0);
      for (int k = 1; k <= 5; k++) begin
        apply(1, 9, 1, 0, 0, 0);
        check("stall_hold", k, 0, (k >= STALL_LIM) ? 6'b000010 : 6'b000000);
      end
      apply(1, 10, 1, 0, 0, 0);
      check("stall_exit", 0, 0, 6'b000000);
    end

    // Randomised phase against the behavioural model.
    begin
      int rq, hold_left, r;
      logic rm, rn;
      rq = 10; rm = 1; hold_left = 0;
      for (int n = 0; n < 1500; n++) begin
        rn = ($urandom_range(0, 99) >= 3);
        if ($urandom_range(0, 9) == 0) rm = ~rm;
        if (hold_left > 0) begin
          hold_left--;
        end else begin
          r = $urandom_range(0, 99);
          if (r < 60) rq = rm ? (rq + 1) % 16 : (rq + 15) % 16;
          else if (r < 88) hold_left = $urandom_range(1, 7);
          else rq = $urandom_range(0, 15);
        end
        apply(rn, rq, rm, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
              ($urandom_range(0, 9) == 0));
        check("random", n, exp_wc, exp_flags);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
